// File: rtl/bin2rns.sv
// bin2rns: serial binary-to-RNS converter, MSB first, one input bit per cycle.
// Produces one-hot residues for moduli 16, 9, 5, 7, 11, 13 and 17.

package rns_pkg;

  typedef struct packed {
    logic [15:0] x16;
    logic [8:0]  x9;
    logic [4:0]  x5;
    logic [6:0]  x7;
    logic [10:0] x11;
    logic [12:0] x13;
    logic [16:0] x17;
  } rns0;

  // Every field holding residue 0 (bit 0 set)
  localparam rns0 RNS_ZERO = '{
    x16: 16'd1, x9: 9'd1, x5: 5'd1, x7: 7'd1,
    x11: 11'd1, x13: 13'd1, x17: 17'd1
  };

endpackage

module bin2rns
  import rns_pkg::*;
#(
  parameter int NBITS = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output rns0              x,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] ysh_q, ysh_d;
  rns0              x_q, x_d;

  logic        bit_in;
  logic [15:0] d16;
  logic [8:0]  d9;
  logic [4:0]  d5;
  logic [6:0]  d7;
  logic [10:0] d11;
  logic [12:0] d13;
  logic [16:0] d17;

  assign bit_in = ysh_q[cnt_q];

  // Doubling permutation r -> 2r mod m on each one-hot field (bit k moves to bit 2k mod m)
  always_comb begin
    d16 = '0;
    d9  = '0;
    d5  = '0;
    d7  = '0;
    d11 = '0;
    d13 = '0;
    d17 = '0;
    for (int k = 0; k < 16; k++) d16[(2*k)%16] = d16[(2*k)%16] | x_q.x16[k];
    for (int k = 0; k < 9;  k++) d9[(2*k)%9]   = d9[(2*k)%9]   | x_q.x9[k];
    for (int k = 0; k < 5;  k++) d5[(2*k)%5]   = d5[(2*k)%5]   | x_q.x5[k];
    for (int k = 0; k < 7;  k++) d7[(2*k)%7]   = d7[(2*k)%7]   | x_q.x7[k];
    for (int k = 0; k < 11; k++) d11[(2*k)%11] = d11[(2*k)%11] | x_q.x11[k];
    for (int k = 0; k < 13; k++) d13[(2*k)%13] = d13[(2*k)%13] | x_q.x13[k];
    for (int k = 0; k < 17; k++) d17[(2*k)%17] = d17[(2*k)%17] | x_q.x17[k];
  end

  // Next-state, shift register, counter and residue update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ysh_d   = ysh_q;
    x_d     = x_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          ysh_d   = y;
          x_d     = RNS_ZERO;
          cnt_d   = CW'(NBITS - 1);
        end
      end
      BUSY: begin
        x_d.x16 = bit_in ? {d16[14:0], d16[15]} : d16;
        x_d.x9  = bit_in ? {d9[7:0],   d9[8]}   : d9;
        x_d.x5  = bit_in ? {d5[3:0],   d5[4]}   : d5;
        x_d.x7  = bit_in ? {d7[5:0],   d7[6]}   : d7;
        x_d.x11 = bit_in ? {d11[9:0],  d11[10]} : d11;
        x_d.x13 = bit_in ? {d13[11:0], d13[12]} : d13;
        x_d.x17 = bit_in ? {d17[15:0], d17[16]} : d17;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ysh_q   <= '0;
      x_q     <= RNS_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ysh_q   <= ysh_d;
      x_q     <= x_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x         = x_q;

endmodule

// File: doc/bin2rns.md
# bin2rns

Serial binary-to-RNS converter, the forward direction of the `rns2bin` path. It accepts a 23-bit unsigned binary word and produces an `rns0` struct of one-hot residues for moduli 16, 9, 5, 7, 11, 13 and 17. The product of the moduli is 12252240, which exceeds 2^23, so every input is representable. It consumes one input bit per cycle, MSB first, with valid/ready handshakes on both sides, and feeds RNS datapaths whose results return through `rns2bin`.

## Interface
Parameters:
- `NBITS`, 23: input width. Fixed to match the `rns2bin` output. Not intended to be overridden.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `y`  in  23  unsigned binary input; sampled only on the accepting edge.
- `in_valid`  in  1  `y` is valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `x`  out  `rns0` (78 bits)  one-hot residues in fields `x16[15:0]`, `x9[8:0]`, `x5[4:0]`, `x7[6:0]`, `x11[10:0]`, `x13[12:0]`, `x17[16:0]`. Bit k set means residue = k.
- `out_valid`  out  1  `x` holds a completed conversion.
- `out_ready`  in  1  downstream accepts `x`.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - BUSY: `in_ready`=0, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- IDLE→BUSY when `in_valid`=1 at a clock edge:
  - Capture `y` into the shift register.
  - Load every residue field with one-hot 0 (bit 0 set).
  - Load bit counter `cnt` = 22.
- BUSY, each cycle:
  - Take b = `ysh[cnt]`.
  - Update every field: r ← (2r + b) mod m. In one-hot form this is a fixed doubling permutation, bit k → bit (2k mod m), followed by a rotate-left by b within the field.
  - Decrement `cnt`.
  - When `cnt`==0 is processed, go to DONE.
- DONE: hold `x` stable. Go to IDLE at the edge where `out_ready`=1.
- No new input is accepted in the same cycle as the output transfer; `in_ready` rises the cycle after.
- `x16` is always `y[3:0]` one-hot, which is a free consistency check.
- `x` keeps its last value in IDLE. It is only meaningful while `out_valid`=1.
- Every field always holds exactly one set bit, including after reset.
- `in_valid` is ignored in BUSY and DONE. Upstream must hold `y` until the handshake completes.

## Timing
- Reset values, applied on the rising edge with `rst`=1:
  - state = IDLE, `in_ready`=1, `out_valid`=0.
  - Every `x` field = one-hot 0 (bit 0 set).
  - `cnt`=0, shift register=0.
- Reset has priority over every other event. Asserting `rst` during BUSY or DONE aborts the conversion. Nothing is emitted afterward and the result is discarded.
- Latency: accept at edge E0; `out_valid` is high after edge E0+23.
- Throughput: one conversion per 25 cycles when `out_ready` is held high (1 accept + 23 BUSY + 1 DONE).
- Backpressure: DONE holds indefinitely and `x` stays constant while `out_ready`=0.
- `out_ready` while not in DONE has no effect.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready`.

## Test plan
- Reset, then `y`=0 → after 23 BUSY cycles every field has bit 0 set and `out_valid`=1 for one cycle with `out_ready`=1.
- `y`=100 → `x16`[4], `x9`[1], `x5`[0], `x7`[2], `x11`[1], `x13`[9], `x17`[15].
- `y`=8388607 → `x16`[15], `x9`[4], `x5`[2], `x7`[3], `x11`[7], `x13`[6], `x17`[8].
- `out_ready` held low for 10 cycles in DONE → `x` and `out_valid` stable. `in_valid` pulses are ignored and `in_ready`=0 throughout. Raising `out_ready` returns to IDLE on the next edge.
- `rst` asserted 5 cycles into BUSY with `y`=12345 → next cycle is IDLE with all fields at one-hot 0 and no `out_valid`. A new conversion of `y`=1 then yields bit 1 in every field.
- Random `y` in 0..8388607, chained into `rns2bin` → the `rns2bin` output equals `y` for 1000 back-to-back conversions.
